// File: rtl/register_file_pkg.sv
// Shared CPU definitions: datapath widths, architectural register indices
// and the active-low reset level used by the pipeline stages.
package cpu_defines;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDRESS_WIDTH = 6;
    localparam int unsigned GPR_COUNT     = 32;

    localparam logic [DATA_WIDTH-1:0]    ZERO_WORD     = '0;
    localparam logic [ADDRESS_WIDTH-1:0] REGISTER_ZERO = 6'd0;
    localparam logic [ADDRESS_WIDTH-1:0] REGISTER_HI   = 6'd32;
    localparam logic [ADDRESS_WIDTH-1:0] REGISTER_LO   = 6'd33;

    localparam logic RESET_ENABLE = 1'b0;

endpackage

// File: rtl/register_read_port.sv
// One operand read port of the register file.
// Ports:
//   reset            synchronous active-low reset level (forces output to 0)
//   read_enable      read request
//   read_address     register index to read
//   write_enable     write-back request (used for same-cycle bypass)
//   write_address    write-back destination
//   write_data       write-back value
//   storage          register contents, entry i holds address i+1
//   read_data        combinational operand value
module register_read_port
    import cpu_defines::*;
#(
    parameter int unsigned DATA_WIDTH    = cpu_defines::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = cpu_defines::ADDRESS_WIDTH,
    parameter int unsigned GPR_COUNT     = cpu_defines::GPR_COUNT
) (
    input  logic                     reset,
    input  logic                     read_enable,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    storage [GPR_COUNT+1],
    output logic [DATA_WIDTH-1:0]    read_data
);

    // Highest writable index: GPRs, then HI, then LO.
    localparam logic [ADDRESS_WIDTH-1:0] LAST_WRITABLE = ADDRESS_WIDTH'(GPR_COUNT + 1);

    always_comb begin
        read_data = '0;
        if (reset == RESET_ENABLE) begin
            read_data = '0;
        end else if (!read_enable) begin
            read_data = '0;
        end else if (read_address == REGISTER_ZERO) begin
            read_data = '0;
        end else if (read_address > LAST_WRITABLE) begin
            read_data = '0;
        end else if (write_enable && (write_address == read_address)) begin
            // Range already checked above, so a match here is always a real register.
            read_data = write_data;
        end else begin
            read_data = storage[read_address - ADDRESS_WIDTH'(1)];
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file: 31 writable GPRs ($0 hard-wired to zero),
// HI and LO, two combinational read ports with write-to-read bypass.
// Ports:
//   clock                     system clock, rising-edge updates
//   reset                     synchronous active-low reset
//   register_a_read_enable    port A read request
//   register_a_read_address   port A index
//   register_a_read_data      port A data (combinational)
//   register_b_read_enable    port B read request
//   register_b_read_address   port B index
//   register_b_read_data      port B data (combinational)
//   write_enable              write-back request
//   write_address             write-back destination
//   write_data                write-back value
module register_file
    import cpu_defines::*;
#(
    parameter int unsigned DATA_WIDTH    = cpu_defines::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = cpu_defines::ADDRESS_WIDTH,
    parameter int unsigned GPR_COUNT     = cpu_defines::GPR_COUNT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     register_a_read_enable,
    input  logic [ADDRESS_WIDTH-1:0] register_a_read_address,
    output logic [DATA_WIDTH-1:0]    register_a_read_data,
    input  logic                     register_b_read_enable,
    input  logic [ADDRESS_WIDTH-1:0] register_b_read_address,
    output logic [DATA_WIDTH-1:0]    register_b_read_data,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data
);

    // No storage for $0: entry i holds address i+1 (GPRs 1..31, HI, LO).
    localparam int unsigned              STORAGE_DEPTH = GPR_COUNT + 1;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_WRITABLE = ADDRESS_WIDTH'(GPR_COUNT + 1);

    logic [DATA_WIDTH-1:0] storage [STORAGE_DEPTH];
    logic                  write_valid;

    assign write_valid = write_enable
                      && (write_address != REGISTER_ZERO)
                      && (write_address <= LAST_WRITABLE);

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            for (int unsigned i = 0; i < STORAGE_DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (write_valid) begin
            storage[write_address - ADDRESS_WIDTH'(1)] <= write_data;
        end
    end

    register_read_port #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .GPR_COUNT     (GPR_COUNT)
    ) port_a (
        .reset         (reset),
        .read_enable   (register_a_read_enable),
        .read_address  (register_a_read_address),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .storage       (storage),
        .read_data     (register_a_read_data)
    );

    register_read_port #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .GPR_COUNT     (GPR_COUNT)
    ) port_b (
        .reset         (reset),
        .read_enable   (register_b_read_enable),
        .read_address  (register_b_read_address),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .storage       (storage),
        .read_data     (register_b_read_data)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: each stimulus cycle pushes the
// expected A/B read data; a monitor pops and compares at the falling edge.
module tb_register_file;

    logic        clock;
    logic        reset;
    logic        register_a_read_enable;
    logic [5:0]  register_a_read_address;
    logic [31:0] register_a_read_data;
    logic        register_b_read_enable;
    logic [5:0]  register_b_read_address;
    logic [31:0] register_b_read_data;
    logic        write_enable;
    logic [5:0]  write_address;
    logic [31:0] write_data;

    typedef struct {
        logic [31:0] expect_a;
        logic [31:0] expect_b;
        string       tag;
    } expect_t;

    expect_t expect_q [$];
    int checks = 0;
    int errors = 0;

    register_file #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (6),
        .GPR_COUNT     (32)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .register_a_read_enable  (register_a_read_enable),
        .register_a_read_address (register_a_read_address),
        .register_a_read_data    (register_a_read_data),
        .register_b_read_enable  (register_b_read_enable),
        .register_b_read_address (register_b_read_address),
        .register_b_read_data    (register_b_read_data),
        .write_enable            (write_enable),
        .write_address           (write_address),
        .write_data              (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: outputs are combinational, so they are valid mid-cycle.
    always @(negedge clock) begin
        if (expect_q.size() > 0) begin
            expect_t e;
            e = expect_q.pop_front();
            checks++;
            if (register_a_read_data !== e.expect_a) begin
                errors++;
                $display("FAIL %s port_a got %h expected %h", e.tag, register_a_read_data, e.expect_a);
            end
            checks++;
            if (register_b_read_data !== e.expect_b) begin
                errors++;
                $display("FAIL %s port_b got %h expected %h", e.tag, register_b_read_data, e.expect_b);
            end
        end
    end

    // One cycle of stimulus; inputs applied just after the rising edge.
    task automatic step(input logic rst, input logic we, input logic [5:0] wa,
                        input logic [31:0] wd, input logic ae, input logic [5:0] aa,
                        input logic be, input logic [5:0] ba,
                        input logic [31:0] ea, input logic [31:0] eb, input string tag);
        expect_t e;
        @(posedge clock);
        #1;
        reset                   = rst;
        write_enable            = we;
        write_address           = wa;
        write_data              = wd;
        register_a_read_enable  = ae;
        register_a_read_address = aa;
        register_b_read_enable  = be;
        register_b_read_address = ba;
        e.expect_a = ea;
        e.expect_b = eb;
        e.tag      = tag;
        expect_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        write_enable = 1'b0;
        write_address = '0;
        write_data = '0;
        register_a_read_enable = 1'b0;
        register_a_read_address = '0;
        register_b_read_enable = 1'b0;
        register_b_read_address = '0;

        //   rst we  wa     wd            ae aa     be ba     expA          expB
        step(0, 0, 6'd0,  32'h0,        1, 6'd5,  1, 6'd32, 32'h0,        32'h0,        "reset_state");
        step(1, 1, 6'd5,  32'h12345678, 0, 6'd0,  0, 6'd0,  32'h0,        32'h0,        "preload_r5");
        step(1, 1, 6'd32, 32'hAAAA5555, 1, 6'd5,  0, 6'd0,  32'h12345678, 32'h0,        "r5_loaded");
        step(0, 0, 6'd0,  32'h0,        1, 6'd5,  1, 6'd32, 32'h0,        32'h0,        "reset_cycle");
        step(1, 0, 6'd0,  32'h0,        1, 6'd5,  1, 6'd32, 32'h0,        32'h0,        "after_reset");
        step(1, 1, 6'd7,  32'hDEADBEEF, 1, 6'd8,  1, 6'd1,  32'h0,        32'h0,        "write_r7");
        step(1, 0, 6'd0,  32'h0,        1, 6'd7,  1, 6'd8,  32'hDEADBEEF, 32'h0,        "latency_r7");
        step(1, 1, 6'd9,  32'hCAFEF00D, 1, 6'd9,  1, 6'd9,  32'hCAFEF00D, 32'hCAFEF00D, "bypass_r9");
        step(1, 1, 6'd0,  32'hFFFFFFFF, 1, 6'd0,  1, 6'd9,  32'h0,        32'hCAFEF00D, "zero_bypass");
        step(1, 0, 6'd0,  32'h0,        1, 6'd0,  1, 6'd1,  32'h0,        32'h0,        "zero_after");
        step(1, 1, 6'd32, 32'h11111111, 1, 6'd32, 1, 6'd33, 32'h11111111, 32'h0,        "write_hi");
        step(1, 1, 6'd33, 32'h22222222, 1, 6'd32, 1, 6'd33, 32'h11111111, 32'h22222222, "write_lo");
        step(1, 1, 6'd40, 32'h33333333, 1, 6'd40, 1, 6'd32, 32'h0,        32'h11111111, "reserved_bypass");
        step(1, 0, 6'd0,  32'h0,        1, 6'd40, 1, 6'd33, 32'h0,        32'h22222222, "reserved_read");
        step(1, 0, 6'd0,  32'h0,        0, 6'd7,  1, 6'd7,  32'h0,        32'hDEADBEEF, "enable_gate");
        step(1, 0, 6'd0,  32'h0,        1, 6'd9,  1, 6'd33, 32'hCAFEF00D, 32'h22222222, "no_side_effect");
        step(0, 1, 6'd10, 32'h00000055, 1, 6'd10, 1, 6'd10, 32'h0,        32'h0,        "reset_with_write");
        step(1, 0, 6'd0,  32'h0,        1, 6'd10, 1, 6'd7,  32'h0,        32'h0,        "r10_dropped");
        step(1, 1, 6'd31, 32'h0F0F0F0F, 1, 6'd63, 1, 6'd31, 32'h0,        32'h0F0F0F0F, "top_gpr_bypass");
        step(1, 1, 6'd1,  32'h00000001, 1, 6'd31, 1, 6'd2,  32'h0F0F0F0F, 32'h0,        "r31_stored");
        step(1, 0, 6'd0,  32'h0,        1, 6'd1,  1, 6'd1,  32'h00000001, 32'h00000001, "r1_both_ports");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && expect_q.size() > 0; i++) @(posedge clock);
        @(posedge clock);
        checks++;
        if (expect_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", expect_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
